sha256_block_engine: RTL
========================

# sha256_block_engine

Iterative, parametrised SHA-256 compression engine that hashes multi-block messages through a valid/ready block input and a valid/ready digest output. It is the successor to the single-shot 512-bit top: it chains the intermediate hash across blocks using first/last framing, and trades area for throughput via a rounds-per-cycle parameter. It sits between the block-padding front end and the digest consumer.

## Interface
- ROUNDS_PER_CYCLE, 1: rounds unrolled per clock; legal values 1, 2, 4, 8; other values are a compile-time error.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  block presented.
- in_ready  out  1  engine can accept a block.
- in_first  in  1  block starts a new message (load IV).
- in_last  in  1  block ends the message (emit digest).
- in_block  in  512  padded block; word W[i] = in_block[32*i+31:32*i], so W0 is in the LSBs.
- out_valid  out  1  digest available.
- out_ready  in  1  consumer accepts digest.
- out_digest  out  256  H[i] = out_digest[32*i+31:32*i], so H0 is in the LSBs.
- busy  out  1  compression in progress.
- proto_err  out  1  sticky; set on framing error; cleared only by reset.

## Operation
- States: IDLE, ROUND, UPDATE, OUT.
- IDLE: in_ready=1. On in_valid&in_ready:
  - latch in_block into the 16-word schedule window;
  - if in_first, or no message is open, load the working vars a..h from IV, else from H;
  - go to ROUND with round counter = 0.
- ROUND: apply ROUNDS_PER_CYCLE rounds per cycle. The schedule window shifts by ROUNDS_PER_CYCLE words per cycle. Counter steps by ROUNDS_PER_CYCLE; after round 63 go to UPDATE.
- UPDATE: H[i] <= base[i] + var[i] mod 2^32, where base is IV for a first block, else H.
  - not last: message stays open, go to IDLE;
  - last: message closes, go to OUT.
- OUT: out_valid=1, out_digest=H held stable. On out_ready go to IDLE.
- Framing errors:
  - in_first=0 with no open message: set proto_err; hash the block from IV as if first.
  - in_first=1 while a message is open: silently abandon the old message and restart; not an error.
- in_first=1 with in_last=1 is a single-block message.
- All additions are 32-bit wrap-around; no carries are kept.

## Timing
- Reset values: in_ready=0 while rst_n low, then 1 from the first edge in IDLE. out_valid=0, busy=0, proto_err=0, out_digest=0, H=0, message closed.
- Accept edge at T. Rounds run on edges T+1 .. T+64/ROUNDS_PER_CYCLE. UPDATE runs on the following edge.
- Accept-to-out_valid latency is 64/ROUNDS_PER_CYCLE+1 cycles: 65 for R=1, 9 for R=8.
- Non-last block: in_ready returns after the same latency. Back-to-back block period is 64/R+2 cycles.
- in_ready=0 in ROUND, UPDATE and OUT. in_valid is ignored there; input fields need only be stable on the accept edge.
- out_valid stays high until out_ready, with no timeout. A digest accepted at edge U allows a new block to be accepted at edge U+1 at the earliest.
- busy=1 in ROUND and UPDATE.
- rst_n low at any point, including mid-ROUND or in OUT: all state clears immediately. No partial digest is emitted.

## Structure
- sha256_pkg holds:
  - K[0:63] round constants and the IV[0:7];
  - the state enum;
  - functions Ch, Maj, Σ0, Σ1, σ0, σ1.
- Sub-module sha256_round: one combinational round, taking a..h, K[t] and W[t] and returning the next a..h. It is instantiated ROUNDS_PER_CYCLE times in a generate chain.
- The message schedule is a 16×32 shift register with ROUNDS_PER_CYCLE new words computed per cycle.

## Test plan
- "abc" single block, R=1: W0=61626380, W15=00000018, others 0, first=last=1 → H0..H7 = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad. out_valid is high exactly 65 cycles after accept.
- Empty message, R=4: W0=80000000, rest 0 → e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855, with latency 17.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", R=1/2/4/8: block 1 first=1 last=0, block 2 first=0 last=1 → 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1. No out_valid after block 1.
- Backpressure: hold out_ready=0 for 20 cycles → digest stable, in_ready=0 throughout. Accept on the release edge, in_ready=1 on the next cycle.
- Framing: "abc" block with first=0 after reset → proto_err=1 and the correct "abc" digest. Separately, in_first=1 mid-message → the new message digest is correct and proto_err stays 0.
- Reset mid-ROUND at round 30 → all outputs 0 immediately. A fresh "abc" afterwards hashes correctly.

Source files
------------

// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 constants, engine state encoding and round helper functions.
package sha256_pkg;
  typedef enum logic [1:0] {IDLE, ROUND, UPDATE, OUT} state_t;
  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] ch(input logic [31:0] e, f, g);
    return (e & f) ^ (~e & g);
  endfunction
  function automatic logic [31:0] maj(input logic [31:0] a, b, c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction
  function automatic logic [255:0] iv_vec();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = IV[i];
    return v;
  endfunction
endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 round; working vars packed with a in the LSBs, h in the MSBs.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] cur,
  input  logic [31:0]  k,
  input  logic [31:0]  w,
  output logic [255:0] nxt
);
  logic [31:0] t1, t2;
  always_comb begin
    t1 = cur[255:224] + bsig1(cur[159:128]) + ch(cur[159:128], cur[191:160], cur[223:192]) + k + w;
    t2 = bsig0(cur[31:0]) + maj(cur[31:0], cur[63:32], cur[95:64]);
    nxt = {cur[223:128], cur[127:96] + t1, cur[95:0], t1 + t2};
  end
endmodule

// File: rtl/sha256_block_engine.sv
// sha256_block_engine: iterative multi-block SHA-256 compressor, ROUNDS_PER_CYCLE rounds per clock.
module sha256_block_engine
  import sha256_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_first,
  input  logic         in_last,
  input  logic [511:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_digest,
  output logic         busy,
  output logic         proto_err
);
  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 8)) begin : g_bad_rpc
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end
  state_t st_q, st_d;
  logic run_q, open_q, first_q, last_q, perr_q, accept, fresh, last_round;
  logic [5:0] cnt_q;
  logic [15:0][31:0] w_q;
  logic [255:0] h_q, v_q, v_rnd;
  // Expand the window by 8 words so any unroll depth can slide by ROUNDS_PER_CYCLE.
  function automatic logic [15:0][31:0] sched_next(input logic [15:0][31:0] w);
    logic [31:0] e [0:23];
    logic [15:0][31:0] r;
    for (int i = 0; i < 16; i++) e[i] = w[i];
    for (int i = 16; i < 24; i++) e[i] = ssig1(e[i-2]) + e[i-7] + ssig0(e[i-15]) + e[i-16];
    for (int i = 0; i < 16; i++) r[i] = e[i+ROUNDS_PER_CYCLE];
    return r;
  endfunction
  for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_rnd
    logic [255:0] s_in, s_out;
    if (j == 0) begin : g_head
      assign s_in = v_q;
    end else begin : g_link
      assign s_in = g_rnd[j-1].s_out;
    end
    sha256_round u_round (.cur(s_in), .k(K[cnt_q + 6'(j)]), .w(w_q[j]), .nxt(s_out));
  end
  assign v_rnd = g_rnd[ROUNDS_PER_CYCLE-1].s_out;
  assign accept = in_valid & in_ready;
  assign fresh = in_first | ~open_q;
  assign last_round = cnt_q == 6'(64 - ROUNDS_PER_CYCLE);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st_q <= IDLE;
    else st_q <= st_d;
  always_comb
    st_d = (st_q == IDLE)   ? (accept ? ROUND : IDLE) :
           (st_q == ROUND)  ? (last_round ? UPDATE : ROUND) :
           (st_q == UPDATE) ? (last_q ? OUT : IDLE) :
                              (out_ready ? IDLE : OUT);
  // run_q holds in_ready low until the first edge after reset release.
  always_comb begin
    in_ready = (st_q == IDLE) && run_q;
    out_valid = st_q == OUT;
    busy = (st_q == ROUND) || (st_q == UPDATE);
    out_digest = h_q;
    proto_err = perr_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      run_q <= 1'b0;
      open_q <= 1'b0;
      first_q <= 1'b0;
      last_q <= 1'b0;
      perr_q <= 1'b0;
      cnt_q <= '0;
      w_q <= '0;
      h_q <= '0;
      v_q <= '0;
    end else begin
      run_q <= 1'b1;
      if (accept) begin
        w_q <= in_block;
        v_q <= fresh ? iv_vec() : h_q;
        first_q <= fresh;
        last_q <= in_last;
        cnt_q <= '0;
        if (!in_first && !open_q) perr_q <= 1'b1;
      end
      if (st_q == ROUND) begin
        v_q <= v_rnd;
        w_q <= sched_next(w_q);
        cnt_q <= cnt_q + 6'(ROUNDS_PER_CYCLE);
      end
      if (st_q == UPDATE) begin
        for (int i = 0; i < 8; i++) h_q[32*i +: 32] <= (first_q ? IV[i] : h_q[32*i +: 32]) + v_q[32*i +: 32];
        open_q <= ~last_q;
      end
    end
endmodule
